// File: rtl/render_stream_source_if.sv
// Beat-stream and command bus of render_stream_source. The FRAME_COUNTER_EN
// macro adds the frame_count signal.
interface render_stream_source_if;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_shape_id;
  logic [11:0] cmd_reg_id;
  logic [31:0] cmd_data;
  logic        program_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [31:0] data_out;
  logic        frame_start;
  logic        frame_done;
`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_count;
`endif

  modport master (
    input  enable, cmd_valid, cmd_shape_id, cmd_reg_id, cmd_data,
    output cmd_ready, program_out, x_out, y_out, data_out, frame_start,
`ifdef FRAME_COUNTER_EN
    output frame_count,
`endif
    output frame_done
  );

  modport slave (
    output enable, cmd_valid, cmd_shape_id, cmd_reg_id, cmd_data,
    input  cmd_ready, program_out, x_out, y_out, data_out, frame_start,
`ifdef FRAME_COUNTER_EN
    input  frame_count,
`endif
    input  frame_done
  );
endinterface

// File: rtl/render_stream_source.sv
// Head of the shape-renderer pipeline: drains buffered commands between frames,
// then raster-scans background pixels. FRAME_COUNTER_EN adds a frame counter.
module render_stream_source #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter logic [31:0] BG_COLOR  = 32'h0000_0000,
  parameter int unsigned CMD_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  render_stream_source_if.master  bus
);

  localparam int unsigned   AW            = $clog2(CMD_DEPTH);
  localparam logic [AW:0]   FULL_CNT      = (AW+1)'(CMD_DEPTH);
  localparam logic [AW:0]   CNT_ONE       = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE       = AW'(1);
  localparam logic [10:0]   X_LAST        = 11'(H_RES - 1);
  localparam logic [11:0]   Y_LAST        = 12'(V_RES - 1);
  localparam logic          FIRST_IS_LAST = (H_RES == 1) && (V_RES == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    SCAN = 2'd2
  } state_e;

  state_e      state_q;
  logic        program_q;
  logic [10:0] x_q;
  logic [11:0] y_q;
  logic [31:0] data_q;
  logic        frame_start_q;
  logic        frame_done_q;

  // Each entry packs {shape_id, reg_id, data}.
  logic [54:0]   mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic        push;
  logic        pop;
  logic [54:0] head;
  logic [10:0] x_d;
  logic [11:0] y_d;
  logic        last_d;

  assign bus.cmd_ready = (count_q != FULL_CNT);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = (state_q != SCAN) && (count_q != {(AW+1){1'b0}});
  assign head = mem_q[rd_ptr_q];

  // Raster position following the current pixel beat.
  always_comb begin
    x_d    = (x_q == X_LAST) ? 11'd0 : x_q + 11'd1;
    y_d    = (x_q == X_LAST) ? y_q + 12'd1 : y_q;
    last_d = (x_d == X_LAST) && (y_d == Y_LAST);
  end

  // Command storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_shape_id, bus.cmd_reg_id, bus.cmd_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Beat sequencer: commands first, then a frame if enabled, otherwise a no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      program_q     <= 1'b1;
      x_q           <= 11'h7FF;
      y_q           <= 12'hFFF;
      data_q        <= 32'h0000_0000;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        IDLE, PROG: begin
          if (pop) begin
            state_q   <= PROG;
            program_q <= 1'b1;
            x_q       <= head[54:44];
            y_q       <= head[43:32];
            data_q    <= head[31:0];
          end else if (bus.enable) begin
            state_q       <= FIRST_IS_LAST ? IDLE : SCAN;
            program_q     <= 1'b0;
            x_q           <= 11'd0;
            y_q           <= 12'd0;
            data_q        <= BG_COLOR;
            frame_start_q <= 1'b1;
            frame_done_q  <= FIRST_IS_LAST;
          end else begin
            state_q   <= IDLE;
            program_q <= 1'b1;
            x_q       <= 11'h7FF;
            y_q       <= 12'hFFF;
            data_q    <= 32'h0000_0000;
          end
        end
        SCAN: begin
          state_q      <= last_d ? IDLE : SCAN;
          program_q    <= 1'b0;
          x_q          <= x_d;
          y_q          <= y_d;
          data_q       <= BG_COLOR;
          frame_done_q <= last_d;
        end
        default: begin
          state_q   <= IDLE;
          program_q <= 1'b1;
          x_q       <= 11'h7FF;
          y_q       <= 12'hFFF;
          data_q    <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign bus.program_out = program_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.data_out    = data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;

`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_count_q;

  // Counts completed frames; a frame cut short by reset never reaches frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= 16'd0;
    end else if (frame_done_q) begin
      frame_count_q <= frame_count_q + 16'd1;
    end else begin
      frame_count_q <= frame_count_q;
    end
  end

  assign bus.frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_render_stream_source.sv
// Scoreboard bench for render_stream_source on a 4x3 raster with a 4-entry FIFO.
module tb_render_stream_source;
  localparam int          H  = 4;
  localparam int          V  = 3;
  localparam int          D  = 4;
  localparam logic [31:0] BG = 32'hCAFE_0001;

  typedef struct packed {
    logic        prog;
    logic [10:0] x;
    logic [11:0] y;
    logic [31:0] data;
    logic        fs;
    logic        fd;
    logic        rdy;
  } beat_t;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        vld;
    logic [10:0] id;
    logic [11:0] rg;
    logic [31:0] d;
  } stim_t;

  logic clk;
  logic rst;
  render_stream_source_if bus_if ();

  render_stream_source #(
    .H_RES(H), .V_RES(V), .BG_COLOR(BG), .CMD_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  beat_t exp_q[$];
  stim_t stim_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t noop();
    beat_t b;
    b.prog = 1'b1; b.x = 11'h7FF; b.y = 12'hFFF; b.data = 32'h0;
    b.fs = 1'b0; b.fd = 1'b0; b.rdy = 1'b1;
    return b;
  endfunction

  function automatic beat_t pix(int x, int y);
    beat_t b;
    b.prog = 1'b0; b.x = 11'(x); b.y = 12'(y); b.data = BG;
    b.fs = (x == 0) && (y == 0);
    b.fd = (x == H - 1) && (y == V - 1);
    b.rdy = 1'b1;
    return b;
  endfunction

  function automatic beat_t prg(logic [10:0] id, logic [11:0] rg, logic [31:0] d);
    beat_t b;
    b.prog = 1'b1; b.x = id; b.y = rg; b.data = d;
    b.fs = 1'b0; b.fd = 1'b0; b.rdy = 1'b1;
    return b;
  endfunction

  function automatic stim_t st(logic r, logic en, logic vld,
                               logic [10:0] id, logic [11:0] rg, logic [31:0] d);
    stim_t s;
    s.rst = r; s.en = en; s.vld = vld; s.id = id; s.rg = rg; s.d = d;
    return s;
  endfunction

  function automatic beat_t observe();
    beat_t b;
    b.prog = bus_if.program_out; b.x = bus_if.x_out; b.y = bus_if.y_out;
    b.data = bus_if.data_out; b.fs = bus_if.frame_start;
    b.fd = bus_if.frame_done; b.rdy = bus_if.cmd_ready;
    return b;
  endfunction

  task automatic drive_next();
    stim_t s;
    s = (stim_q.size() > 0) ? stim_q.pop_front() : '0;
    rst                 = s.rst;
    bus_if.enable       = s.en;
    bus_if.cmd_valid    = s.vld;
    bus_if.cmd_shape_id = s.id;
    bus_if.cmd_reg_id   = s.rg;
    bus_if.cmd_data     = s.d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    beat_t got, exp;
    int n = 0;
    repeat (2) stim_q.push_back(st(1'b1, 1'b0, 1'b0, 11'd0, 12'd0, 32'd0));
    repeat (7) exp_q.push_back(noop());
    while (exp_q.size() > 0) begin
      drive_next(); step(); got = observe(); exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL reset beat %0d: got %h expected %h", n, got, exp);
      else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_frame();
    beat_t got, exp;
    int n = 0;
    repeat (13) stim_q.push_back(st(1'b0, 1'b1, 1'b0, 11'd0, 12'd0, 32'd0));
    for (int i = 0; i < H * V; i++) exp_q.push_back(pix(i % H, i / H));
    for (int i = 0; i < H * V; i++) exp_q.push_back(pix(i % H, i / H));
    exp_q.push_back(noop());
    while (exp_q.size() > 0) begin
      drive_next(); step(); got = observe(); exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL frame beat %0d: got %h expected %h", n, got, exp);
      else pass_cnt++;
      n++;
    end
`ifdef FRAME_COUNTER_EN
    total_cnt++;
    if (bus_if.frame_count !== 16'd2)
      $display("FAIL frame_count after two frames: got %0d expected 2", bus_if.frame_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_cmds_idle();
    beat_t got, exp;
    int n = 0;
    stim_q.push_back(st(1'b0, 1'b0, 1'b1, 11'd0, 12'd0, 32'd10));
    stim_q.push_back(st(1'b0, 1'b1, 1'b1, 11'd0, 12'd1, 32'd20));
    stim_q.push_back(st(1'b0, 1'b1, 1'b1, 11'd0, 12'd4, 32'hFF00_FF00));
    repeat (2) stim_q.push_back(st(1'b0, 1'b1, 1'b0, 11'd0, 12'd0, 32'd0));
    exp_q.push_back(noop());
    exp_q.push_back(prg(11'd0, 12'd0, 32'd10));
    exp_q.push_back(prg(11'd0, 12'd1, 32'd20));
    exp_q.push_back(prg(11'd0, 12'd4, 32'hFF00_FF00));
    for (int i = 0; i < H * V; i++) exp_q.push_back(pix(i % H, i / H));
    exp_q.push_back(noop());
    while (exp_q.size() > 0) begin
      drive_next(); step(); got = observe(); exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL cmds_idle beat %0d: got %h expected %h", n, got, exp);
      else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_cmds_mid_scan();
    beat_t got, exp;
    int n = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 3)      stim_q.push_back(st(1'b0, 1'b1, 1'b1, 11'd5, 12'd7, 32'h1234_5678));
      else if (c == 4) stim_q.push_back(st(1'b0, 1'b1, 1'b1, 11'd6, 12'd9, 32'h8765_4321));
      else             stim_q.push_back(st(1'b0, 1'b1, 1'b0, 11'd0, 12'd0, 32'd0));
    end
    for (int i = 0; i < H * V; i++) exp_q.push_back(pix(i % H, i / H));
    exp_q.push_back(prg(11'd5, 12'd7, 32'h1234_5678));
    exp_q.push_back(prg(11'd6, 12'd9, 32'h8765_4321));
    for (int i = 0; i < H * V; i++) exp_q.push_back(pix(i % H, i / H));
    exp_q.push_back(noop());
    while (exp_q.size() > 0) begin
      drive_next(); step(); got = observe(); exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL cmds_mid_scan beat %0d: got %h expected %h", n, got, exp);
      else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_fifo_full();
    beat_t got, exp, b;
    int n = 0;
    stim_q.push_back(st(1'b0, 1'b1, 1'b0, 11'd0, 12'd0, 32'd0));
    for (int k = 1; k <= 4; k++)
      stim_q.push_back(st(1'b0, 1'b0, 1'b1, 11'(k), 12'(k + 100), 32'(k * 1111)));
    repeat (9) stim_q.push_back(st(1'b0, 1'b0, 1'b1, 11'd5, 12'd105, 32'hE5E5_E5E5));
    for (int i = 0; i < H * V; i++) begin
      b = pix(i % H, i / H);
      b.rdy = (i < 4) ? 1'b1 : 1'b0;
      exp_q.push_back(b);
    end
    for (int k = 1; k <= 4; k++) exp_q.push_back(prg(11'(k), 12'(k + 100), 32'(k * 1111)));
    exp_q.push_back(prg(11'd5, 12'd105, 32'hE5E5_E5E5));
    exp_q.push_back(noop());
    while (exp_q.size() > 0) begin
      drive_next(); step(); got = observe(); exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL fifo_full beat %0d: got %h expected %h", n, got, exp);
      else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_mid_reset();
    beat_t got, exp;
    int n = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0 || c == 8) stim_q.push_back(st(1'b0, 1'b1, 1'b0, 11'd0, 12'd0, 32'd0));
      else if (c == 2)      stim_q.push_back(st(1'b0, 1'b0, 1'b1, 11'd3, 12'd3, 32'hDEAD_BEEF));
      else if (c == 7)      stim_q.push_back(st(1'b1, 1'b0, 1'b0, 11'd0, 12'd0, 32'd0));
      else                  stim_q.push_back(st(1'b0, 1'b0, 1'b0, 11'd0, 12'd0, 32'd0));
    end
    for (int i = 0; i <= 6; i++) exp_q.push_back(pix(i % H, i / H));
    exp_q.push_back(noop());
    for (int i = 0; i < H * V; i++) exp_q.push_back(pix(i % H, i / H));
    exp_q.push_back(noop());
    while (exp_q.size() > 0) begin
      drive_next(); step(); got = observe(); exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL mid_reset beat %0d: got %h expected %h", n, got, exp);
      else pass_cnt++;
      n++;
    end
`ifdef FRAME_COUNTER_EN
    total_cnt++;
    if (bus_if.frame_count !== 16'd1)
      $display("FAIL frame_count after reset and one frame: got %0d expected 1", bus_if.frame_count);
    else pass_cnt++;
`endif
  endtask

  initial begin
    rst                 = 1'b1;
    bus_if.enable       = 1'b0;
    bus_if.cmd_valid    = 1'b0;
    bus_if.cmd_shape_id = 11'd0;
    bus_if.cmd_reg_id   = 12'd0;
    bus_if.cmd_data     = 32'd0;
    test_reset();
    test_frame();
    test_cmds_idle();
    test_cmds_mid_scan();
    test_fifo_full();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
